sub32_pipe: RTL and testbench
=============================

Name: sub32_pipe

Overview:
- Registered 32-bit subtractor with borrow-in and borrow-out, the inverse-direction companion to the team's registered carry-lookahead adder.
- Computes d = a − b − bi through two pipeline stages (operand register, result register) with a valid/ready handshake on both sides, so upstream and downstream can stall.
- Also produces status flags for the datapath's compare and branch logic.
- Arithmetic is a + ~b + ~bi, which lets it reuse the existing 32-bit CLA adder as the stage-1 combinational core.

Parameters:
- WIDTH, 32, operand/result width in bits (only 32 is verified).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bi are valid this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bi  input  1  borrow-in (1 = subtract one more)
- out_valid  output  1  result outputs valid
- out_ready  input  1  downstream accepts result this cycle
- d  output  WIDTH  difference, modulo 2^WIDTH
- bo  output  1  borrow-out, unsigned a < b + bi
- ov  output  1  signed overflow
- z  output  1  d == 0

Behaviour:
- Reset: asynchronous assertion (reset_n low) immediately clears s1_valid and s2_valid, and all data registers go to 0.
  - Outputs in reset: out_valid=0, d=0, bo=0, ov=0, z=0.
  - in_ready=1 during and after reset.
  - Deassertion is synchronised externally. First capture is on the first rising edge with reset_n high.
- Stage 1 (operand registers): reg_a, reg_b, reg_bi, s1_valid. These are loaded when in_valid && in_ready.
- Combinational core on stage-1 registers:
  - sum = reg_a + ~reg_b + ~reg_bi (WIDTH+1 bits).
  - d_next = sum[WIDTH-1:0].
  - bo_next = ~sum[WIDTH] (carry-out inverted).
  - ov_next = (reg_a[MSB] != reg_b[MSB]) && (d_next[MSB] != reg_a[MSB]).
  - z_next = (d_next == 0).
- Stage 2 (result registers): d, bo, ov, z, s2_valid. These are loaded from the core when s1_valid && s2_free.
- Handshake:
  - s2_free = ~s2_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = ~s1_valid | s2_free. This is a combinational path from out_ready and is permitted.
  - On each clk edge:
    - s2_valid <= s1_valid if s2_free, else it holds.
    - s1_valid <= (in_valid & in_ready) if (~s1_valid | s2_free), else it holds.
- Latency: an operand accepted on edge N appears with out_valid=1 after edge N+1, when no stall occurs.
- Throughput: one result per cycle while out_ready=1.
- Stall rules:
  - While out_valid=1 and out_ready=0, d/bo/ov/z/out_valid hold stable.
  - Stage 1 holds its operand and in_ready=0 once both stages are full.
  - No transaction is dropped or duplicated.
- Simultaneous events:
  - Accept and retire in the same cycle is allowed at both stages, giving a full-pipeline pass-through.
  - out_ready with out_valid=0 has no effect.
  - in_valid with in_ready=0 leaves the operands unsampled. Upstream must hold them.
- Flags are registered with d and refer only to that transaction.
- Wrap-around: d is modulo 2^32.
  - 0 − 1 gives 0xFFFFFFFF with bo=1.
  - 0 − 0 − 1 gives the same result.
- Reset mid-operation: all in-flight transactions are discarded. No output pulse follows reset.

Test Plan:
- Reset with in_valid=1, a=5 → out_valid=0, d=0, in_ready=1. Release reset; the first result d=5−b appears after 2 edges.
- Streaming with out_ready=1: a=10,b=3,bi=0 then a=0,b=1,bi=0 then a=7,b=7,bi=0 → consecutive outputs:
  - d=7, bo=0, z=0
  - d=0xFFFFFFFF, bo=1, ov=0
  - d=0, z=1, bo=0
- Signed overflow: a=0x80000000, b=1 → d=0x7FFFFFFF, ov=1, bo=0. Then a=0x7FFFFFFF, b=0xFFFFFFFF → d=0x80000000, ov=1, bo=1.
- Borrow-in: a=5, b=5, bi=1 → d=0xFFFFFFFF, bo=1, z=0. Then a=0, b=0, bi=1 → d=0xFFFFFFFF, bo=1.
- Back-pressure: send 4 operands back-to-back while out_ready=0.
  - in_ready drops after 2 accepts. Outputs hold the first result stable.
  - Raise out_ready → 4 results emerge in order with no loss or duplication.
- Reset asserted while both stages are full and stalled → out_valid=0 immediately (asynchronous). After release, no stale result appears.

Source files
------------

// File: rtl/sub32_pipe.sv
// sub32_pipe: two-stage registered subtractor (a - b - bi) with borrow/overflow/zero flags and valid/ready handshake
module sub32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov,
  output logic             z
);
  logic [WIDTH-1:0] reg_a, reg_b, d_next;
  logic             reg_bi, s1_valid, s2_valid, s2_free;
  logic             bo_next, ov_next, z_next;
  logic [WIDTH:0]   sum;
  assign s2_free   = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_free;
  assign out_valid = s2_valid;
  // a + ~b + ~bi keeps the core a plain adder; carry-out low means a borrow occurred
  always_comb begin
    sum     = {1'b0, reg_a} + {1'b0, ~reg_b} + {{WIDTH{1'b0}}, ~reg_bi};
    d_next  = sum[WIDTH-1:0];
    bo_next = ~sum[WIDTH];
    ov_next = (reg_a[WIDTH-1] != reg_b[WIDTH-1]) && (d_next[WIDTH-1] != reg_a[WIDTH-1]);
    z_next  = (d_next == '0);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      reg_a    <= '0;
      reg_b    <= '0;
      reg_bi   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        reg_a  <= a;
        reg_b  <= b;
        reg_bi <= bi;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      d        <= '0;
      bo       <= 1'b0;
      ov       <= 1'b0;
      z        <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        d  <= d_next;
        bo <= bo_next;
        ov <= ov_next;
        z  <= z_next;
      end
    end
  end
endmodule

// File: tb/tb_sub32_pipe.sv
// tb_sub32_pipe: directed vectors with hand-computed results for sub32_pipe
module tb_sub32_pipe;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bi = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] d;
  logic        bo, ov, z;
  int n_checks = 0;
  int n_errors = 0;
  typedef struct packed {
    logic [31:0] a, b;
    logic        bi;
    logic [31:0] d;
    logic        bo, ov, z;
  } vec_t;
  vec_t v [11] = '{
    '{32'd10,         32'd3,          1'b0, 32'd7,          1'b0, 1'b0, 1'b0},
    '{32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0},
    '{32'd7,          32'd7,          1'b0, 32'd0,          1'b0, 1'b0, 1'b1},
    '{32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0},
    '{32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  1'b1, 1'b1, 1'b0},
    '{32'd5,          32'd5,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0},
    '{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0},
    '{32'd100,        32'd1,          1'b0, 32'd99,         1'b0, 1'b0, 1'b0},
    '{32'd200,        32'd50,         1'b0, 32'd150,        1'b0, 1'b0, 1'b0},
    '{32'd3,          32'd4,          1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0},
    '{32'd1,          32'd0,          1'b1, 32'd0,          1'b0, 1'b0, 1'b1}
  };

  sub32_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bo(bo), .ov(ov), .z(z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    a  = v[i].a;
    b  = v[i].b;
    bi = v[i].bi;
  endtask

  task automatic check_res(input int i);
    check($sformatf("out_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
    check($sformatf("d[%0d]", i), d, v[i].d);
    check($sformatf("bo[%0d]", i), {31'd0, bo}, {31'd0, v[i].bo});
    check($sformatf("ov[%0d]", i), {31'd0, ov}, {31'd0, v[i].ov});
    check($sformatf("z[%0d]", i), {31'd0, z}, {31'd0, v[i].z});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    in_valid = 1'b1;
    a = 32'd5;
    b = 32'd2;
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_flags", {29'd0, bo, ov, z}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    step();
    in_valid = 1'b0;
    check("first_latency", {31'd0, out_valid}, 32'd0);
    step();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_d", d, 32'd3);
    step();
    check("first_drain", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      drive(i);
      step();
      if (i > 0) check_res(i - 1);
    end
    in_valid = 1'b0;
    step();
    check_res(6);
    step();
    check("stream_drain", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    drive(7);
    step();
    check("bp_ready1", {31'd0, in_ready}, 32'd1);
    drive(8);
    step();
    check("bp_ready2", {31'd0, in_ready}, 32'd0);
    check_res(7);
    drive(9);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold_ready%0d", k), {31'd0, in_ready}, 32'd0);
      check_res(7);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    check_res(7);
    step();
    check_res(8);
    drive(10);
    step();
    check_res(9);
    in_valid = 1'b0;
    step();
    check_res(10);
    step();
    check("bp_drain", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    drive(0);
    step();
    drive(1);
    step();
    in_valid = 1'b0;
    check_res(0);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_d", d, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("no_stale%0d", k), {31'd0, out_valid}, 32'd0);
    end
    drive(3);
    step();
    in_valid = 1'b0;
    step();
    check_res(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
